watch_mode_sequencer: RTL and testbench
=======================================

WATCH_MODE_SEQUENCER -- requirements
Module: watch_mode_sequencer

Interface
REQ-001 Parameter: IDLE_SEC, 30, seconds of button inactivity before auto-return to watch mode (legal range 1..63).
REQ-002 Port: clk  in  1  system clock; all logic on rising edge.
REQ-003 Port: reset_p  in  1  reset, synchronous and active-high.
REQ-004 Port: btn_mode  in  1  one-cycle edge pulse from the mode button controller.
REQ-005 Port: btn_fn  in  3  one-cycle edge pulses of function buttons [2:0].
REQ-006 Port: alarm_req  in  1  level from cook-timer; high while the alarm is sounding.
REQ-007 Port: tick_1s  in  1  one-cycle pulse per second.
REQ-008 Port: mode_sel  out  3  one-hot display select: 001 timer, 010 stopwatch, 100 watch.
REQ-009 Port: timer_btn, stopwatch_btn, watch_btn  out  3 each  routed function-button pulses.
REQ-010 Port: mode_changed  out  1  one-cycle pulse on every mode_sel change.

Function
REQ-011 The FSM SHALL have the states S_TIMER, S_STOPWATCH, S_WATCH and S_ALARM, and SHALL hold a 2-bit saved_mode register.
REQ-012 In S_TIMER, S_STOPWATCH and S_WATCH, a btn_mode pulse SHALL advance the state TIMER->STOPWATCH->WATCH->TIMER.
REQ-013 Output timing SHALL be as follows:
- mode_sel and mode_changed are registered.
- They reflect the new state in cycle n+1 after a cause in cycle n.
REQ-014 A rising edge of alarm_req (0 in n-1, 1 in n) while in S_STOPWATCH or S_WATCH SHALL take the following actions:
- Store the current mode in saved_mode.
- Enter S_ALARM; mode_sel=001 in cycle n+1.
REQ-015 A rising edge of alarm_req while in S_TIMER SHALL leave the state unchanged and SHALL NOT pulse mode_changed.
REQ-016 In S_ALARM, btn_mode SHALL be ignored and btn_fn SHALL route to timer_btn.
REQ-017 In S_ALARM, alarm_req low SHALL return the FSM to saved_mode, with mode_changed pulsed.
REQ-018 An alarm rising edge and btn_mode in the same cycle SHALL resolve as follows:
- The alarm wins and the btn_mode pulse is discarded.
- saved_mode is the pre-pulse mode.
REQ-019 btn_fn routing SHALL work as follows:
- A btn_fn pulse in cycle n is copied in cycle n+1 only onto the bus of the mode active in cycle n.
- The other two buses are 000.
REQ-020 A btn_fn pulse coinciding with btn_mode, an alarm edge, or an auto-return in cycle n SHALL be dropped, with all buses 000 in n+1.
REQ-021 Each routed bus SHALL be high for exactly one cycle per input pulse and SHALL never stretch.
REQ-022 Idle timing SHALL work as follows:
- A 6-bit idle_cnt increments on tick_1s and saturates at 63.
- idle_cnt clears on any btn_fn bit or btn_mode pulse; a clear in the same cycle as tick_1s takes priority.
REQ-023 When idle_cnt reaches IDLE_SEC in S_TIMER or S_STOPWATCH, the block SHALL take the following actions:
- Enter S_WATCH in the next cycle.
- Pulse mode_changed.
- Clear idle_cnt.
REQ-024 The auto-return SHALL never fire in S_ALARM or S_WATCH.
REQ-025 An alarm rising edge SHALL take priority over an auto-return in the same cycle.
REQ-026 An unreachable or illegal state encoding SHALL recover to S_WATCH on the next clock.

Reset
REQ-027 While reset_p is high at a clock edge, the block SHALL set the following values:
- State S_TIMER, saved_mode = timer, idle_cnt = 0, mode_sel = 001.
- All button buses = 000, mode_changed = 0.
- The alarm edge detector history = 0.
REQ-028 A reset asserted mid-alarm SHALL clear S_ALARM, and the block SHALL NOT re-enter S_ALARM unless alarm_req shows a fresh 0->1 edge after reset release.

Configuration
REQ-029 The macro AUTO_RETURN_EN SHALL control the idle auto-return feature.
- Defined: idle_cnt and REQ-022..REQ-025 are compiled in.
- Undefined: no idle counter logic exists, the mode changes only via btn_mode or alarm, and tick_1s is unused.

Verification
REQ-030 Reset, then three btn_mode pulses -> mode_sel 001->010->100->001, with one mode_changed pulse each, each one cycle after its btn_mode pulse.
REQ-031 In S_WATCH, raise alarm_req, pulse btn_fn=010, then drop alarm_req -> expected response:
- mode_sel=001 one cycle after the alarm edge.
- timer_btn=010 for one cycle.
- mode_sel back to 100 one cycle after the fall.
REQ-032 In S_STOPWATCH, btn_fn=001 together with btn_mode -> all buses stay 000 and mode_sel=100.
REQ-033 With AUTO_RETURN_EN and IDLE_SEC=3, in S_STOPWATCH, no buttons for 3 tick_1s pulses -> mode_sel=100 with a mode_changed pulse.
- Same case with a btn_fn pulse after 2 ticks -> no return until 3 further ticks.
REQ-034 Alarm rising edge and btn_mode in the same cycle while in S_WATCH -> expected response:
- Enters S_ALARM.
- After alarm_req falls, mode_sel=100, not 001.
REQ-035 Assert reset_p for one cycle during S_ALARM with alarm_req held high -> expected response:
- mode_sel=001 after reset.
- No S_ALARM entry until alarm_req goes 0 then 1.

Source files
------------

// File: rtl/watch_mode_sequencer_if.sv
// Button, alarm and display-select bundle shared by the mode sequencer and
// whatever drives it. The master side owns the inputs to the sequencer.
interface watch_mode_sequencer_if;
   logic       btn_mode;
   logic [2:0] btn_fn;
   logic       alarm_req;
   logic       tick_1s;
   logic [2:0] mode_sel;
   logic [2:0] timer_btn;
   logic [2:0] stopwatch_btn;
   logic [2:0] watch_btn;
   logic       mode_changed;

   modport master (
      output btn_mode, btn_fn, alarm_req, tick_1s,
      input  mode_sel, timer_btn, stopwatch_btn, watch_btn, mode_changed
   );

   modport slave (
      input  btn_mode, btn_fn, alarm_req, tick_1s,
      output mode_sel, timer_btn, stopwatch_btn, watch_btn, mode_changed
   );
endinterface

// File: rtl/watch_mode_sequencer.sv
// Watch mode sequencer: cycles timer/stopwatch/watch on the mode button,
// pre-empts into an alarm view while the cook-timer alarm sounds, routes
// function buttons to the active mode and (optionally) falls back to watch
// mode after a period of button inactivity.
// Optional feature macro: AUTO_RETURN_EN (idle auto-return to watch mode).
module watch_mode_sequencer #(
   parameter int IDLE_SEC = 30
) (
   input  logic                   clk,
   input  logic                   reset_p,
   watch_mode_sequencer_if.slave  bus
);

   if (IDLE_SEC < 1 || IDLE_SEC > 63) begin : g_idle_sec_range
      $error("watch_mode_sequencer: IDLE_SEC must be within 1..63");
   end

   typedef enum logic [1:0] {
      S_TIMER     = 2'd0,
      S_STOPWATCH = 2'd1,
      S_WATCH     = 2'd2,
      S_ALARM     = 2'd3
   } state_t;

   // Bus index of each routed function-button output.
   localparam int B_TIMER = 0;
   localparam int B_SW    = 1;
   localparam int B_WATCH = 2;

   state_t           state_q, state_d;
   logic [1:0]       saved_mode_q, saved_mode_d;
   logic             alarm_d1_q;
   logic [2:0]       mode_sel_q, mode_sel_d;
   logic             mode_changed_q, mode_changed_d;
   logic [2:0][2:0]  fn_bus_q, fn_bus_d;

   logic             alarm_rise;
   logic             auto_ret;
   logic             fn_drop;

   assign alarm_rise = bus.alarm_req & ~alarm_d1_q;

`ifdef AUTO_RETURN_EN
   logic [5:0] idle_cnt_q, idle_cnt_d;
   logic       idle_clr;

   // Return only from the two "setting" modes; the alarm view and the watch
   // itself never time out.
   assign auto_ret = ((state_q == S_TIMER) || (state_q == S_STOPWATCH)) &&
                     (idle_cnt_q >= 6'(IDLE_SEC));

   // An alarm edge pre-empts the return, so the counter is only cleared when
   // the return is actually taken.
   assign idle_clr = (|bus.btn_fn) | bus.btn_mode | (auto_ret & ~alarm_rise);

   // Idle counter: button activity beats a coincident tick; saturates at 63.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (idle_clr) begin
         idle_cnt_d = 6'd0;
      end else if (bus.tick_1s && (idle_cnt_q != 6'd63)) begin
         idle_cnt_d = idle_cnt_q + 6'd1;
      end
   end

   // Idle counter register.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         idle_cnt_q <= 6'd0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   assign auto_ret = 1'b0;
`endif

   // Display select for a state; the alarm view shows the timer.
   function automatic logic [2:0] sel_of(input state_t s);
      case (s)
         S_STOPWATCH: sel_of = 3'b010;
         S_WATCH:     sel_of = 3'b100;
         default:     sel_of = 3'b001;
      endcase
   endfunction

   // Next state: alarm edge, then auto-return, then the mode button.
   always_comb begin
      state_d      = state_q;
      saved_mode_d = saved_mode_q;
      case (state_q)
         S_TIMER, S_STOPWATCH, S_WATCH: begin
            if (alarm_rise) begin
               // An alarm already shows on the timer display; stay put there.
               if (state_q != S_TIMER) begin
                  saved_mode_d = state_q;
                  state_d      = S_ALARM;
               end
            end else if (auto_ret) begin
               state_d = S_WATCH;
            end else if (bus.btn_mode) begin
               case (state_q)
                  S_TIMER:     state_d = S_STOPWATCH;
                  S_STOPWATCH: state_d = S_WATCH;
                  default:     state_d = S_TIMER;
               endcase
            end
         end
         S_ALARM: begin
            if (!bus.alarm_req) begin
               case (saved_mode_q)
                  2'd0:    state_d = S_TIMER;
                  2'd1:    state_d = S_STOPWATCH;
                  default: state_d = S_WATCH;
               endcase
            end
         end
         default: state_d = S_WATCH;
      endcase
   end

   // Registered outputs: display select, change pulse, routed buttons.
   always_comb begin
      mode_sel_d     = sel_of(state_d);
      mode_changed_d = (mode_sel_d != mode_sel_q);
      fn_drop        = bus.btn_mode | alarm_rise | auto_ret;
      fn_bus_d       = '0;
      if (!fn_drop) begin
         case (state_q)
            S_STOPWATCH: fn_bus_d[B_SW]    = bus.btn_fn;
            S_WATCH:     fn_bus_d[B_WATCH] = bus.btn_fn;
            default:     fn_bus_d[B_TIMER] = bus.btn_fn;
         endcase
      end
   end

   // State, saved mode, alarm history and output registers.
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state_q        <= S_TIMER;
         saved_mode_q   <= 2'd0;
         alarm_d1_q     <= 1'b0;
         mode_sel_q     <= 3'b001;
         mode_changed_q <= 1'b0;
         fn_bus_q       <= '0;
      end else begin
         state_q        <= state_d;
         saved_mode_q   <= saved_mode_d;
         alarm_d1_q     <= bus.alarm_req;
         mode_sel_q     <= mode_sel_d;
         mode_changed_q <= mode_changed_d;
         fn_bus_q       <= fn_bus_d;
      end
   end

   assign bus.mode_sel      = mode_sel_q;
   assign bus.mode_changed  = mode_changed_q;
   assign bus.timer_btn     = fn_bus_q[B_TIMER];
   assign bus.stopwatch_btn = fn_bus_q[B_SW];
   assign bus.watch_btn     = fn_bus_q[B_WATCH];

endmodule

// File: tb/tb_watch_mode_sequencer.sv
// Bench for watch_mode_sequencer: directed scenarios followed by random
// traffic, with a cycle-level reference model feeding a scoreboard queue.
module tb_watch_mode_sequencer;
   localparam int IDLE = 3;

   logic clk = 1'b0;
   logic reset_p = 1'b1;
   always #5 clk = ~clk;

   watch_mode_sequencer_if bif();

   watch_mode_sequencer #(.IDLE_SEC(IDLE)) dut (
      .clk     (clk),
      .reset_p (reset_p),
      .bus     (bif.slave)
   );

   typedef struct packed {
      logic [2:0] sel;
      logic [2:0] tb;
      logic [2:0] sb;
      logic [2:0] wb;
      logic       mc;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model: mode 0 timer, 1 stopwatch, 2 watch, 3 alarm.
   int m_mode  = 0;
   int m_saved = 0;
   int m_idle  = 0;
   bit m_prev  = 0;

   function automatic logic [2:0] sel_for(input int md);
      return (md == 1) ? 3'b010 : (md == 2) ? 3'b100 : 3'b001;
   endfunction

   task automatic model_step(input bit bm, input bit [2:0] fn, input bit a,
                             input bit tk, input bit r, output exp_t e);
      bit rise, auto, drop;
      int nm, route;
      e = '0;
      if (r) begin
         m_mode = 0; m_saved = 0; m_idle = 0; m_prev = 0;
         e.sel = 3'b001;
         return;
      end
      rise = a && !m_prev;
`ifdef AUTO_RETURN_EN
      auto = (m_mode == 0 || m_mode == 1) && (m_idle >= IDLE);
`else
      auto = 0;
`endif
      drop = bm || rise || auto;
      nm = m_mode;
      if (m_mode == 3) begin
         if (!a) nm = m_saved;
      end else if (rise) begin
         if (m_mode != 0) begin m_saved = m_mode; nm = 3; end
      end else if (auto) begin
         nm = 2;
      end else if (bm) begin
         nm = (m_mode + 1) % 3;
      end
      route = (m_mode == 3) ? 0 : m_mode;
      if (!drop) begin
         if (route == 0) e.tb = fn;
         if (route == 1) e.sb = fn;
         if (route == 2) e.wb = fn;
      end
      if (fn != 0 || bm || (auto && !rise)) m_idle = 0;
      else if (tk && m_idle < 63) m_idle = m_idle + 1;
      e.sel = sel_for(nm);
      e.mc  = (sel_for(nm) != sel_for(m_mode));
      m_mode = nm;
      m_prev = a;
   endtask

   // One stimulus cycle: drive at the falling edge, queue the expected output.
   task automatic cyc(input bit bm = 0, input bit [2:0] fn = 3'b000,
                      input bit a = 0, input bit tk = 0, input bit r = 0);
      exp_t e;
      @(negedge clk);
      reset_p      = r;
      bif.btn_mode = bm;
      bif.btn_fn   = fn;
      bif.alarm_req = a;
      bif.tick_1s  = tk;
      model_step(bm, fn, a, tk, r, e);
      q.push_back(e);
   endtask

   task automatic wait_out();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   // Monitor: every clock presents a full output word; compare with the queue.
   always @(posedge clk) begin
      exp_t e, g;
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         g = {bif.mode_sel, bif.timer_btn, bif.stopwatch_btn, bif.watch_btn, bif.mode_changed};
         n_chk++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL scoreboard @%0t: got sel=%b t=%b s=%b w=%b mc=%b expected sel=%b t=%b s=%b w=%b mc=%b",
                     $time, g.sel, g.tb, g.sb, g.wb, g.mc, e.sel, e.tb, e.sb, e.wb, e.mc);
         end
      end
   end

   initial begin
      bif.btn_mode = 0; bif.btn_fn = 0; bif.alarm_req = 0; bif.tick_1s = 0;

      // Reset state
      cyc(.r(1)); cyc(.r(1));
      wait_out(); chk("reset_sel", bif.mode_sel, 3'b001);
      chk("reset_buses", bif.timer_btn | bif.stopwatch_btn | bif.watch_btn, 3'b000);

      // Mode rotation
      cyc(.bm(1)); wait_out(); chk("rot_sw", bif.mode_sel, 3'b010);
      chk("rot_sw_mc", {2'b00, bif.mode_changed}, 3'b001);
      cyc(); wait_out(); chk("rot_mc_low", {2'b00, bif.mode_changed}, 3'b000);
      cyc(.bm(1)); wait_out(); chk("rot_watch", bif.mode_sel, 3'b100);
      cyc(.bm(1)); wait_out(); chk("rot_timer", bif.mode_sel, 3'b001);

      // Alarm from watch with a function button during the alarm
      cyc(.bm(1)); cyc(.bm(1)); cyc();
      cyc(.a(1)); wait_out(); chk("alarm_sel", bif.mode_sel, 3'b001);
      cyc(.a(1), .fn(3'b010)); wait_out(); chk("alarm_fn_timer", bif.timer_btn, 3'b010);
      chk("alarm_fn_watch", bif.watch_btn, 3'b000);
      cyc(.a(1)); wait_out(); chk("alarm_fn_oneshot", bif.timer_btn, 3'b000);
      cyc(.a(0)); wait_out(); chk("alarm_return", bif.mode_sel, 3'b100);

      // Function button together with the mode button is dropped
      cyc(.bm(1)); cyc(.bm(1));
      cyc(.bm(1), .fn(3'b001)); wait_out(); chk("fn_drop_sel", bif.mode_sel, 3'b100);
      chk("fn_drop_buses", bif.timer_btn | bif.stopwatch_btn | bif.watch_btn, 3'b000);

      // Alarm edge and mode button together: alarm wins, saved mode is watch
      cyc(); cyc(.a(1), .bm(1)); wait_out(); chk("coinc_alarm", bif.mode_sel, 3'b001);
      cyc(.a(1)); cyc(.a(0)); wait_out(); chk("coinc_return", bif.mode_sel, 3'b100);

      // Reset mid-alarm with the alarm held high
      cyc(.a(1)); wait_out(); chk("rst_alarm_in", bif.mode_sel, 3'b001);
      cyc(.a(1), .r(1)); wait_out(); chk("rst_alarm_sel", bif.mode_sel, 3'b001);
      cyc(.a(1)); cyc(.a(1)); cyc(.a(1));
      cyc(.a(1), .bm(1)); wait_out(); chk("rst_no_alarm", bif.mode_sel, 3'b010);
      cyc(.a(0)); cyc(.a(1)); wait_out(); chk("rst_fresh_edge", bif.mode_sel, 3'b001);
      cyc(.a(0)); wait_out(); chk("rst_fresh_ret", bif.mode_sel, 3'b010);

`ifdef AUTO_RETURN_EN
      // Idle auto-return from stopwatch
      cyc(.bm(1)); cyc(.bm(1)); cyc(.bm(1));
      cyc(.tk(1)); cyc(.tk(1)); cyc(.tk(1));
      cyc(); wait_out(); chk("auto_ret_sel", bif.mode_sel, 3'b100);
      chk("auto_ret_mc", {2'b00, bif.mode_changed}, 3'b001);
      // A function button restarts the idle period
      cyc(.bm(1)); cyc(.bm(1));
      cyc(.tk(1)); cyc(.tk(1)); cyc(.fn(3'b001));
      cyc(.tk(1)); cyc(.tk(1)); cyc(); wait_out(); chk("auto_hold", bif.mode_sel, 3'b010);
      cyc(.tk(1)); cyc(); wait_out(); chk("auto_ret2", bif.mode_sel, 3'b100);
`endif

      // Random traffic
      begin
         bit a = 0;
         for (int i = 0; i < 3000; i++) begin
            bit bm, tk, r;
            bit [2:0] fn;
            bm = ($urandom_range(0, 7) == 0);
            fn = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            tk = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) a = ~a;
            cyc(.bm(bm), .fn(fn), .a(a), .tk(tk), .r(r));
         end
      end

      cyc();
      wait_out();
      #2;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
